vga_timing_aot: RTL and testbench

Parametrised VGA timing generator. It produces the current raster position, sync pulses and blanking, plus a second coordinate stream running a configurable number of pixels ahead of the current one. Drawing logic consumes the ahead-of-time (aot) stream so that its pipeline output lines up with the displayed pixel. It replaces the pairing of a plain timing generator with combinational lookahead arithmetic in the top level. It also adds registered sync, line, frame and vblank strobes, a frame counter and an optional pixel clock-enable.

---
 rtl/vga_timing_pkg.sv | 54 +++++
 rtl/vga_axis_counter.sv | 45 ++++
 rtl/vga_timing_aot.sv | 159 +++++++++++++++
 tb/tb_vga_timing_aot.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//    Shared VGA timing definitions: the 640x480@60 default timing, a struct
//    grouping the eight timing values, and width helpers used by the timing
//    generator and by drawing logic that has to size its own coordinate buses.
//    No ports (package).
package vga_timing_pkg;

   // 640x480@60 defaults (25.175 MHz pixel clock)
   localparam int DEF_H_VISIBLE_AREA = 32'd640;
   localparam int DEF_H_FRONT_PORCH  = 32'd16;
   localparam int DEF_H_SYNC_PULSE   = 32'd96;
   localparam int DEF_H_BACK_PORCH   = 32'd48;
   localparam int DEF_V_VISIBLE_AREA = 32'd480;
   localparam int DEF_V_FRONT_PORCH  = 32'd10;
   localparam int DEF_V_SYNC_PULSE   = 32'd2;
   localparam int DEF_V_BACK_PORCH   = 32'd33;

   // Depth of the drawing pipeline that consumes the aot stream
   localparam int PIPELINE_STAGES    = 32'd2;

   typedef struct packed {
      int h_visible_area;
      int h_front_porch;
      int h_sync_pulse;
      int h_back_porch;
      int v_visible_area;
      int v_front_porch;
      int v_sync_pulse;
      int v_back_porch;
   } vga_timing_t;

   localparam vga_timing_t VGA_640X480_60 = '{
      h_visible_area : DEF_H_VISIBLE_AREA,
      h_front_porch  : DEF_H_FRONT_PORCH,
      h_sync_pulse   : DEF_H_SYNC_PULSE,
      h_back_porch   : DEF_H_BACK_PORCH,
      v_visible_area : DEF_V_VISIBLE_AREA,
      v_front_porch  : DEF_V_FRONT_PORCH,
      v_sync_pulse   : DEF_V_SYNC_PULSE,
      v_back_porch   : DEF_V_BACK_PORCH
   };

   // Total length of one axis (visible + front porch + sync + back porch)
   function automatic int line_total(input int visible, input int front,
                                     input int sync, input int back);
      return visible + front + sync + back;
   endfunction

   // Bits needed to address 0..count-1; never narrower than one bit
   function automatic int addr_width(input int count);
      return (count > 32'd1) ? $clog2(count) : 32'd1;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//    Wrapping counter for one raster axis: counts 0..MAX and wraps to 0.
//    load returns the counter to INIT on the next edge and wins over en.
//    Ports:
//       clk        in   clock
//       en         in   advance by one on this edge
//       load       in   synchronous reload to INIT (used as reset)
//       value      out  registered count
//       value_next out  value the counter takes on the next edge
//       carry      out  en while value == MAX (wrap happens on this edge)
module vga_axis_counter #(
   parameter int MAX   = 32'd799,
   parameter int INIT  = 32'd0,
   parameter int WIDTH = 32'd10
)(
   input  logic             clk,
   input  logic             en,
   input  logic             load,
   output logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] value_next,
   output logic             carry
);

   assign carry = en & (value == WIDTH'(MAX));

   // Next count: reload, hold, wrap or increment
   always_comb begin
      value_next = value;
      if (load) begin
         value_next = WIDTH'(INIT);
      end else if (!en) begin
         value_next = value;
      end else if (value == WIDTH'(MAX)) begin
         value_next = '0;
      end else begin
         value_next = value + WIDTH'(1'b1);
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      value <= value_next;
   end

endmodule

// File: rtl/vga_timing_aot.sv
// vga_timing_aot
//    VGA timing generator with a second coordinate stream running LOOKAHEAD
//    pixels ahead, so drawing pipelines fed from the aot stream line up with
//    the displayed pixel. All outputs are registered; sync, enable and strobe
//    outputs are decoded from next-state coordinates so they align with sx/sy.
//    Optional macro VGA_PIX_CE_EN adds pix_ce: everything advances only on
//    edges with pix_ce = 1 and strobes last one clock per event.
//    Ports:
//       vga_pix_clk          in   clock
//       rst_n                in   synchronous active-low reset
//       pix_ce               in   pixel advance enable (VGA_PIX_CE_EN only)
//       sx, sy               out  current position
//       display_enabled      out  current position visible
//       h_sync, v_sync       out  sync outputs aligned with sx/sy
//       sx_aot, sy_aot       out  position LOOKAHEAD pixels ahead
//       display_enabled_aot  out  aot position visible
//       line_stb_aot         out  sx_aot just became 0
//       frame_stb_aot        out  aot stream just reached (0,0)
//       vblank_stb           out  current stream just reached (0, V_VISIBLE_AREA)
//       frame_cnt            out  completed-frame count
module vga_timing_aot
   import vga_timing_pkg::*;
#(
   parameter int   H_VISIBLE_AREA  = DEF_H_VISIBLE_AREA,
   parameter int   H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
   parameter int   H_SYNC_PULSE    = DEF_H_SYNC_PULSE,
   parameter int   H_BACK_PORCH    = DEF_H_BACK_PORCH,
   parameter int   V_VISIBLE_AREA  = DEF_V_VISIBLE_AREA,
   parameter int   V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
   parameter int   V_SYNC_PULSE    = DEF_V_SYNC_PULSE,
   parameter int   V_BACK_PORCH    = DEF_V_BACK_PORCH,
   parameter int   LOOKAHEAD       = PIPELINE_STAGES,
   parameter logic H_SYNC_POL      = 1'b0,
   parameter logic V_SYNC_POL      = 1'b0,
   parameter int   FRAME_CNT_WIDTH = 32'd8,
   localparam int  H_WHOLE_LINE    = line_total(H_VISIBLE_AREA, H_FRONT_PORCH,
                                                H_SYNC_PULSE, H_BACK_PORCH),
   localparam int  V_WHOLE_LINE    = line_total(V_VISIBLE_AREA, V_FRONT_PORCH,
                                                V_SYNC_PULSE, V_BACK_PORCH),
   localparam int  H_ADDR_WIDTH    = addr_width(H_WHOLE_LINE),
   localparam int  V_ADDR_WIDTH    = addr_width(V_WHOLE_LINE)
)(
   input  logic                       vga_pix_clk,
   input  logic                       rst_n,
`ifdef VGA_PIX_CE_EN
   input  logic                       pix_ce,
`endif
   output logic [H_ADDR_WIDTH-1:0]    sx,
   output logic [V_ADDR_WIDTH-1:0]    sy,
   output logic                       display_enabled,
   output logic                       h_sync,
   output logic                       v_sync,
   output logic [H_ADDR_WIDTH-1:0]    sx_aot,
   output logic [V_ADDR_WIDTH-1:0]    sy_aot,
   output logic                       display_enabled_aot,
   output logic                       line_stb_aot,
   output logic                       frame_stb_aot,
   output logic                       vblank_stb,
   output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);

   localparam int H_SYNC_START = H_VISIBLE_AREA + H_FRONT_PORCH;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_PULSE;
   localparam int V_SYNC_START = V_VISIBLE_AREA + V_FRONT_PORCH;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_PULSE;

   logic                    adv_s;
   logic                    load_s;
   logic [H_ADDR_WIDTH-1:0] sx_next_s;
   logic [V_ADDR_WIDTH-1:0] sy_next_s;
   logic [H_ADDR_WIDTH-1:0] sx_aot_next_s;
   logic [V_ADDR_WIDTH-1:0] sy_aot_next_s;
   logic                    sx_carry_s;
   logic                    sy_carry_s;
   logic                    sx_aot_carry_s;
   logic                    sy_aot_carry_s;
   logic                    h_sync_next_s;
   logic                    v_sync_next_s;
   logic                    de_next_s;
   logic                    de_aot_next_s;

`ifdef VGA_PIX_CE_EN
   assign adv_s = pix_ce;
`else
   assign adv_s = 1'b1;
`endif

   // Reset reloads every counter, overriding any advance on the same edge
   assign load_s = ~rst_n;

   vga_axis_counter #(.MAX(H_WHOLE_LINE - 32'd1), .INIT(32'd0), .WIDTH(H_ADDR_WIDTH)) u_sx (
      .clk(vga_pix_clk), .en(adv_s), .load(load_s),
      .value(sx), .value_next(sx_next_s), .carry(sx_carry_s)
   );

   vga_axis_counter #(.MAX(V_WHOLE_LINE - 32'd1), .INIT(32'd0), .WIDTH(V_ADDR_WIDTH)) u_sy (
      .clk(vga_pix_clk), .en(sx_carry_s), .load(load_s),
      .value(sy), .value_next(sy_next_s), .carry(sy_carry_s)
   );

   // The aot pair starts LOOKAHEAD pixels in and steps in lockstep, so it
   // stays exactly LOOKAHEAD pixels ahead modulo one frame
   vga_axis_counter #(.MAX(H_WHOLE_LINE - 32'd1), .INIT(LOOKAHEAD), .WIDTH(H_ADDR_WIDTH)) u_sx_aot (
      .clk(vga_pix_clk), .en(adv_s), .load(load_s),
      .value(sx_aot), .value_next(sx_aot_next_s), .carry(sx_aot_carry_s)
   );

   vga_axis_counter #(.MAX(V_WHOLE_LINE - 32'd1), .INIT(32'd0), .WIDTH(V_ADDR_WIDTH)) u_sy_aot (
      .clk(vga_pix_clk), .en(sx_aot_carry_s), .load(load_s),
      .value(sy_aot), .value_next(sy_aot_next_s), .carry(sy_aot_carry_s)
   );

   // Sync and visibility levels for the coordinates taken on this edge
   always_comb begin
      h_sync_next_s = ~H_SYNC_POL;
      v_sync_next_s = ~V_SYNC_POL;
      if ((int'(sx_next_s) >= H_SYNC_START) && (int'(sx_next_s) < H_SYNC_END)) begin
         h_sync_next_s = H_SYNC_POL;
      end else begin
         h_sync_next_s = ~H_SYNC_POL;
      end
      if ((int'(sy_next_s) >= V_SYNC_START) && (int'(sy_next_s) < V_SYNC_END)) begin
         v_sync_next_s = V_SYNC_POL;
      end else begin
         v_sync_next_s = ~V_SYNC_POL;
      end
      de_next_s     = (int'(sx_next_s) < H_VISIBLE_AREA) && (int'(sy_next_s) < V_VISIBLE_AREA);
      de_aot_next_s = (int'(sx_aot_next_s) < H_VISIBLE_AREA) && (int'(sy_aot_next_s) < V_VISIBLE_AREA);
   end

   // Registered sync, enables, strobes and frame counter
   always_ff @(posedge vga_pix_clk) begin
      if (!rst_n) begin
         h_sync              <= ~H_SYNC_POL;
         v_sync              <= ~V_SYNC_POL;
         display_enabled     <= 1'b1;
         display_enabled_aot <= (LOOKAHEAD < H_VISIBLE_AREA);
         line_stb_aot        <= (LOOKAHEAD == 32'd0);
         frame_stb_aot       <= (LOOKAHEAD == 32'd0);
         vblank_stb          <= 1'b0;
         frame_cnt           <= '0;
      end else begin
         h_sync              <= h_sync_next_s;
         v_sync              <= v_sync_next_s;
         display_enabled     <= de_next_s;
         display_enabled_aot <= de_aot_next_s;
         // Carries only fire on an advancing edge, so strobes last one clock
         line_stb_aot        <= sx_aot_carry_s;
         frame_stb_aot       <= sy_aot_carry_s;
         vblank_stb          <= sx_carry_s && (int'(sy_next_s) == V_VISIBLE_AREA);
         if (sy_carry_s) begin
            frame_cnt <= frame_cnt + FRAME_CNT_WIDTH'(1'b1);
         end else begin
            frame_cnt <= frame_cnt;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_aot.sv
// tb_vga_timing_aot
//    Three instances: default 640x480 timing (LOOKAHEAD=2), a tiny 17x10
//    raster with LOOKAHEAD at its maximum and inverted sync polarity, and the
//    same tiny raster with LOOKAHEAD=0. A linear-position model predicts every
//    output each cycle; a few literal expectations pin the model itself.
`timescale 1ns/1ps
module tb_vga_timing_aot;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
`ifdef VGA_PIX_CE_EN
   logic pix_ce = 1'b0;
   wire  ce_now = pix_ce;
   localparam int PH1 = 36000;
`else
   wire  ce_now = 1'b1;
   localparam int PH1 = 9000;
`endif
   localparam int PH2 = 20000;

   // Model parameters per instance
   int HV [3] = '{640, 10, 10};
   int HF [3] = '{16, 2, 2};
   int HS [3] = '{96, 3, 3};
   int HB [3] = '{48, 2, 2};
   int VV [3] = '{480, 6, 6};
   int VF [3] = '{10, 1, 1};
   int VS [3] = '{2, 2, 2};
   int VB [3] = '{33, 1, 1};
   int LA [3] = '{2, 16, 0};
   int HP [3] = '{0, 1, 0};
   int VP [3] = '{0, 1, 0};

   int pos [3];
   int fcm [3];
   int checks = 0;
   int errors = 0;

   logic [9:0] a_sx, a_sxa, a_sy, a_sya;
   logic [4:0] b_sx, b_sxa, c_sx, c_sxa;
   logic [3:0] b_sy, b_sya, c_sy, c_sya;
   logic [7:0] a_fc, b_fc, c_fc;
   logic a_de, a_hs, a_vs, a_dea, a_ls, a_fs, a_vb;
   logic b_de, b_hs, b_vs, b_dea, b_ls, b_fs, b_vb;
   logic c_de, c_hs, c_vs, c_dea, c_ls, c_fs, c_vb;

   vga_timing_aot u_a (
      .vga_pix_clk(clk), .rst_n(rst_n),
`ifdef VGA_PIX_CE_EN
      .pix_ce(pix_ce),
`endif
      .sx(a_sx), .sy(a_sy), .display_enabled(a_de), .h_sync(a_hs), .v_sync(a_vs),
      .sx_aot(a_sxa), .sy_aot(a_sya), .display_enabled_aot(a_dea),
      .line_stb_aot(a_ls), .frame_stb_aot(a_fs), .vblank_stb(a_vb), .frame_cnt(a_fc)
   );

   vga_timing_aot #(
      .H_VISIBLE_AREA(10), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(2),
      .V_VISIBLE_AREA(6), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
      .LOOKAHEAD(16), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
   ) u_b (
      .vga_pix_clk(clk), .rst_n(rst_n),
`ifdef VGA_PIX_CE_EN
      .pix_ce(pix_ce),
`endif
      .sx(b_sx), .sy(b_sy), .display_enabled(b_de), .h_sync(b_hs), .v_sync(b_vs),
      .sx_aot(b_sxa), .sy_aot(b_sya), .display_enabled_aot(b_dea),
      .line_stb_aot(b_ls), .frame_stb_aot(b_fs), .vblank_stb(b_vb), .frame_cnt(b_fc)
   );

   vga_timing_aot #(
      .H_VISIBLE_AREA(10), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(2),
      .V_VISIBLE_AREA(6), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
      .LOOKAHEAD(0)
   ) u_c (
      .vga_pix_clk(clk), .rst_n(rst_n),
`ifdef VGA_PIX_CE_EN
      .pix_ce(pix_ce),
`endif
      .sx(c_sx), .sy(c_sy), .display_enabled(c_de), .h_sync(c_hs), .v_sync(c_vs),
      .sx_aot(c_sxa), .sy_aot(c_sya), .display_enabled_aot(c_dea),
      .line_stb_aot(c_ls), .frame_stb_aot(c_fs), .vblank_stb(c_vb), .frame_cnt(c_fc)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected outputs from the instance's linear raster position
   task automatic check_dut(input int d, input int mode,
                            input int sx, input int sy, input int sxa, input int sya,
                            input int de, input int hs, input int vs, input int dea,
                            input int ls, input int fs, input int vb, input int fc);
      int h, v, t, x, y, q, qx, qy, e_hs, e_vs, e_ls, e_fs, e_vb;
      string p;
      h  = HV[d] + HF[d] + HS[d] + HB[d];
      v  = VV[d] + VF[d] + VS[d] + VB[d];
      t  = h * v;
      x  = pos[d] % h;
      y  = pos[d] / h;
      q  = (pos[d] + LA[d]) % t;
      qx = q % h;
      qy = q / h;
      e_hs = (x >= HV[d] + HF[d] && x < HV[d] + HF[d] + HS[d]) ? HP[d] : 1 - HP[d];
      e_vs = (y >= VV[d] + VF[d] && y < VV[d] + VF[d] + VS[d]) ? VP[d] : 1 - VP[d];
      if (mode == 0) begin
         e_ls = (LA[d] == 0); e_fs = (LA[d] == 0); e_vb = 0;
      end else if (mode == 1) begin
         e_ls = (qx == 0); e_fs = (q == 0); e_vb = (x == 0 && y == VV[d]);
      end else begin
         e_ls = 0; e_fs = 0; e_vb = 0;
      end
      p = $sformatf("dut%0d ", d);
      chk({p, "sx"}, sx, x);
      chk({p, "sy"}, sy, y);
      chk({p, "sx_aot"}, sxa, qx);
      chk({p, "sy_aot"}, sya, qy);
      chk({p, "display_enabled"}, de, (x < HV[d] && y < VV[d]));
      chk({p, "display_enabled_aot"}, dea, (qx < HV[d] && qy < VV[d]));
      chk({p, "h_sync"}, hs, e_hs);
      chk({p, "v_sync"}, vs, e_vs);
      chk({p, "line_stb_aot"}, ls, e_ls);
      chk({p, "frame_stb_aot"}, fs, e_fs);
      chk({p, "vblank_stb"}, vb, e_vb);
      chk({p, "frame_cnt"}, fc, fcm[d]);
   endtask

   // Compare process: update model on each edge, then check all instances
   initial begin
      int mode;
      bit model_ok = 1'b0;
      bit pinned_reset = 1'b0;
      bit wrap_pend = 1'b0;
      int hs_cnt = 0, hs_first = -1, hs_last = -1;
      forever begin
         @(posedge clk);
         if (!rst_n) mode = 0;
         else if (ce_now) mode = 1;
         else mode = 2;
         #1;
         for (int d = 0; d < 3; d++) begin
            if (mode == 0) begin
               pos[d] = 0; fcm[d] = 0;
            end else if (mode == 1) begin
               pos[d] = (pos[d] + 1) % ((HV[d] + HF[d] + HS[d] + HB[d]) * (VV[d] + VF[d] + VS[d] + VB[d]));
               if (pos[d] == 0) fcm[d] = (fcm[d] + 1) % 256;
            end
         end
         if (mode == 0) model_ok = 1'b1;
         if (model_ok) begin
            check_dut(0, mode, a_sx, a_sy, a_sxa, a_sya, a_de, a_hs, a_vs, a_dea, a_ls, a_fs, a_vb, a_fc);
            check_dut(1, mode, b_sx, b_sy, b_sxa, b_sya, b_de, b_hs, b_vs, b_dea, b_ls, b_fs, b_vb, b_fc);
            check_dut(2, mode, c_sx, c_sy, c_sxa, c_sya, c_de, c_hs, c_vs, c_dea, c_ls, c_fs, c_vb, c_fc);
            // Literal pins
            if (mode == 0 && !pinned_reset) begin
               pinned_reset = 1'b1;
               chk("pin reset sx", a_sx, 0);
               chk("pin reset sy", a_sy, 0);
               chk("pin reset sx_aot", a_sxa, 2);
               chk("pin reset sy_aot", a_sya, 0);
               chk("pin reset h_sync", a_hs, 1);
               chk("pin reset v_sync", a_vs, 1);
               chk("pin reset frame_cnt", a_fc, 0);
               chk("pin reset display_enabled", a_de, 1);
               chk("pin reset vblank_stb", a_vb, 0);
               chk("pin reset lookahead0 line_stb", c_ls, 1);
            end
            if (mode == 1 && pos[0] == 10 * 800 + 798) begin
               chk("pin wrap sx_aot", a_sxa, 0);
               chk("pin wrap sy_aot", a_sya, 11);
               chk("pin wrap line_stb_aot", a_ls, 1);
               wrap_pend = 1'b1;
            end else if (mode == 1 && wrap_pend) begin
               wrap_pend = 1'b0;
               chk("pin after wrap sx", a_sx, 799);
               chk("pin after wrap sx_aot", a_sxa, 1);
               chk("pin after wrap line_stb_aot", a_ls, 0);
            end
            if (mode == 1 && pos[0] / 800 == 5 && a_hs == 1'b0) begin
               hs_cnt++;
               if (hs_first < 0) hs_first = pos[0] % 800;
               hs_last = pos[0] % 800;
            end
            if (mode == 1 && pos[0] == 6 * 800) begin
               chk("pin hsync width", hs_cnt, 96);
               chk("pin hsync first", hs_first, 656);
               chk("pin hsync last", hs_last, 751);
            end
            if (mode == 1 && b_fs == 1'b1) begin
               chk("pin max lookahead frame_stb sx", b_sx, 1);
               chk("pin max lookahead frame_stb sy", b_sy, 9);
            end
            if (mode == 1 && pos[1] % 17 == 12) chk("pin inverted h_sync", b_hs, 1);
            if (mode == 1 && pos[1] == 7 * 17) chk("pin inverted v_sync", b_vs, 1);
            if (mode == 1 && pos[2] == 7 * 17) chk("pin v_sync", c_vs, 0);
            if (mode == 1 && pos[2] == 0 && fcm[2] == 1) chk("pin first frame_cnt", c_fc, 1);
            chk("lookahead0 sx_aot==sx", c_sxa, c_sx);
            chk("lookahead0 sy_aot==sy", c_sya, c_sy);
         end
      end
   end

   // Stimulus: initial reset, long clean run, then random resets / enables
   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < PH1; i++) begin
         rst_n = 1'b1;
`ifdef VGA_PIX_CE_EN
         pix_ce = (i % 4 == 3);
`endif
         @(negedge clk);
      end
      for (int i = 0; i < PH2; i++) begin
         rst_n = ($urandom_range(0, 299) != 0);
`ifdef VGA_PIX_CE_EN
         pix_ce = $urandom_range(0, 1);
`endif
         @(negedge clk);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
